// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-period and counter-width helpers, line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_e;

    // Serial line level while no frame is on the wire.
    localparam logic TX_IDLE = 1'b1;

    // Clock cycles per bit (integer truncation).
    function automatic int unsigned calc_div(input int unsigned clock_hz, input int unsigned baud);
        return clock_hz / baud;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// One-bit-period timer: counts 0..DIV-1, bit_end_o is high on the last cycle of each bit.
// A held restart parks the count at zero so the first bit starts cleanly after release.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned DIV   = 868,
    parameter int unsigned CNT_W = cnt_width(DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             bit_end_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             end_q;

    // Bit-period counter; end flag is registered alongside the count that reaches DIV-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            end_q <= 1'b0;
        end else if (restart_i || end_q) begin
            cnt_q <= '0;
            end_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            end_q <= (cnt_q == CNT_W'(DIV - 2));
        end
    end

    assign cnt_o     = cnt_q;
    assign bit_end_o = end_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from the TX FIFO and frames them onto the tx line
// (start, WIDTH data bits LSB-first, optional even parity, 1 or 2 stop bits).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CLOCK_HZ  = 100_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_read,
    output logic             tx,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam int unsigned DIV   = calc_div(CLOCK_HZ, BAUD);
    localparam int unsigned CNT_W = cnt_width(DIV);
    localparam int unsigned BIT_W = cnt_width(WIDTH);
    localparam int unsigned NSTOP = (STOP_BITS == 2) ? 2 : 1;

    uart_state_e      state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             stop_cnt_q;
    logic             tx_q;
    logic             fifo_read_q;
    logic             busy_q;
    logic             done_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic             restart;
    logic [CNT_W-1:0] tcnt;
    logic             bit_end;

    // Timer is held at zero until the start bit begins, so every bit is exactly DIV cycles.
    assign restart = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);

    uart_bit_timer #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .restart_i (restart),
        .cnt_o     (tcnt),
        .bit_end_o (bit_end)
    );

    // Frame sequencer with registered line, pop, busy and done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= TX_IDLE;
            fifo_read_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            fifo_read_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= TX_IDLE;
                    if (!fifo_empty) begin
                        fifo_read_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_POP;
                    end
                end
                ST_POP: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_q    <= fifo_data;
`ifdef UART_TX_PARITY_EN
                    parity_q   <= ^fifo_data;
`endif
                    tx_q       <= 1'b0;
                    bit_cnt_q  <= '0;
                    stop_cnt_q <= 1'b0;
                    state_q    <= ST_START;
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= TX_IDLE;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= TX_IDLE;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    tx_q <= TX_IDLE;
                    // Registered pulse lands on the final cycle of the last stop bit.
                    done_q <= (stop_cnt_q == 1'(NSTOP - 1)) && (tcnt == CNT_W'(DIV - 2));
                    if (bit_end) begin
                        if (stop_cnt_q == 1'(NSTOP - 1)) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= TX_IDLE;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign fifo_read  = fifo_read_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: two instances (1 and 2 stop bits) fed by FIFO models;
// expected line frames are queued at push time and checked by per-instance line monitors.
module tb_uart_tx_serializer;

    localparam int unsigned W      = 8;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD_R = 100_000;
    localparam int          DIV    = CLK_HZ / BAUD_R;
`ifdef UART_TX_PARITY_EN
    localparam int          PAR    = 1;
`else
    localparam int          PAR    = 0;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       fifo_empty_w = 2'b11;
    logic [W-1:0]     fifo_data_w [2] = '{default: '0};
    logic [1:0]       fifo_read_w;
    logic [1:0]       tx_w;
    logic [1:0]       busy_w;
    logic [1:0]       done_w;

    int               tests = 0;
    int               fails = 0;
    int               cyc   = 0;
    bit               mon_en = 1'b1;
    logic             glitch0 = 1'b0;
    int               pushes [2] = '{0, 0};
    int               reads  [2] = '{0, 0};
    logic [W-1:0]     fq0[$];
    logic [W-1:0]     fq1[$];
    logic [15:0]      eq0[$];
    logic [15:0]      eq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_serializer #(.WIDTH(W), .CLOCK_HZ(CLK_HZ), .BAUD(BAUD_R), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .fifo_data(fifo_data_w[0]), .fifo_empty(fifo_empty_w[0]),
        .fifo_read(fifo_read_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .frame_done(done_w[0]));

    uart_tx_serializer #(.WIDTH(W), .CLOCK_HZ(CLK_HZ), .BAUD(BAUD_R), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .fifo_data(fifo_data_w[1]), .fifo_empty(fifo_empty_w[1]),
        .fifo_read(fifo_read_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .frame_done(done_w[1]));

    task automatic check_eq(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference frame: list of line levels, one entry per bit period, first entry first on the wire.
    function automatic logic [15:0] build_frame(input logic [W-1:0] d);
        logic [15:0] f;
        int p;
        f = '1;
        f[0] = 1'b0;
        p = 1;
        for (int i = 0; i < W; i++) begin
            f[p] = d[i];
            p++;
        end
        if (PAR == 1) f[p] = ^d;
        return f;
    endfunction

    task automatic push_byte(input int k, input logic [W-1:0] d);
        if (k == 0) begin
            fq0.push_back(d);
            eq0.push_back(build_frame(d));
        end else begin
            fq1.push_back(d);
            eq1.push_back(build_frame(d));
        end
        pushes[k]++;
    endtask

    // FIFO models: data registered the cycle after a pop, empty flag registered.
    always @(posedge clk) begin
        if (fifo_read_w[0]) begin
            reads[0]++;
            check_eq("pop_nonempty0", int'(fq0.size() > 0), 1);
            if (fq0.size() > 0) fifo_data_w[0] <= fq0.pop_front();
        end
        if (fifo_read_w[1]) begin
            reads[1]++;
            check_eq("pop_nonempty1", int'(fq1.size() > 0), 1);
            if (fq1.size() > 0) fifo_data_w[1] <= fq1.pop_front();
        end
        fifo_empty_w[0] <= (fq0.size() == 0) && !glitch0;
        fifo_empty_w[1] <= (fq1.size() == 0);
    end

    task automatic monitor(input int k);
        logic        prev_tx = 1'b1;
        logic        prev_busy = 1'b0;
        logic        prev_empty = 1'b1;
        bit          post_chk = 1'b0;
        bit          gap_chk = 1'b0;
        int          rd_cyc = -1000;
        int          efall_cyc = -1;
        int          gap = 0;
        int          nb, match, done_at, done_cnt, busy_low, rd_in;
        bit          have;
        logic [15:0] fr;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_tx = tx_w[k]; prev_busy = busy_w[k]; prev_empty = fifo_empty_w[k];
                post_chk = 1'b0; gap_chk = 1'b0;
                continue;
            end
            if (post_chk) begin
                post_chk = 1'b0;
                check_eq($sformatf("k%0d busy_after_frame", k), int'(busy_w[k]), 0);
            end
            if (!fifo_empty_w[k] && prev_empty && !busy_w[k]) efall_cyc = cyc;
            if (fifo_read_w[k]) begin
                rd_cyc = cyc;
                check_eq($sformatf("k%0d read_only_in_idle", k), int'(prev_busy), 0);
                if (efall_cyc >= 0) begin
                    check_eq($sformatf("k%0d read_latency", k), rd_cyc - efall_cyc, 1);
                    efall_cyc = -1;
                end
            end
            if (prev_tx && !tx_w[k]) begin
                check_eq($sformatf("k%0d read_to_start", k), cyc - rd_cyc, 2);
                if (gap_chk) check_eq($sformatf("k%0d idle_gap", k), gap, 3);
                gap_chk = 1'b0;
                have = 1'b0;
                fr = '1;
                if (k == 0 && eq0.size() > 0) begin have = 1'b1; fr = eq0.pop_front(); end
                if (k == 1 && eq1.size() > 0) begin have = 1'b1; fr = eq1.pop_front(); end
                check_eq($sformatf("k%0d frame_expected", k), int'(have), 1);
                nb = 1 + W + PAR + (k + 1);
                done_at = 0; done_cnt = 0; busy_low = 0; rd_in = 0;
                for (int b = 0; b < nb; b++) begin
                    match = 0;
                    for (int c = 0; c < DIV; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (tx_w[k] === fr[b]) match++;
                        if (!busy_w[k]) busy_low++;
                        if (fifo_read_w[k]) rd_in++;
                        if (done_w[k]) begin
                            done_cnt++;
                            if (done_at == 0) done_at = b * DIV + c + 1;
                        end
                    end
                    check_eq($sformatf("k%0d bit%0d cycles_at_level_%0d", k, b, fr[b]), match, DIV);
                end
                check_eq($sformatf("k%0d frame_done_cycle", k), done_at, nb * DIV);
                check_eq($sformatf("k%0d frame_done_pulses", k), done_cnt, 1);
                check_eq($sformatf("k%0d busy_low_in_frame", k), busy_low, 0);
                check_eq($sformatf("k%0d read_in_frame", k), rd_in, 0);
                gap_chk = !fifo_empty_w[k];
                gap = 0;
                post_chk = 1'b1;
                prev_tx = tx_w[k]; prev_busy = busy_w[k]; prev_empty = fifo_empty_w[k];
                continue;
            end
            if (tx_w[k]) gap++;
            prev_tx = tx_w[k]; prev_busy = busy_w[k]; prev_empty = fifo_empty_w[k];
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(fq0.size() == 0 && fq1.size() == 0 && eq0.size() == 0 && eq1.size() == 0 &&
                 busy_w == 2'b00 && fifo_empty_w == 2'b11)) begin
            @(negedge clk);
            n++;
            if (n > 4000) begin
                tests++; fails++;
                $display("[TB] FAIL idle_timeout: frames still pending after %0d cycles", n);
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("k%0d rst_tx", k), int'(tx_w[k]), 1);
            check_eq($sformatf("k%0d rst_fifo_read", k), int'(fifo_read_w[k]), 0);
            check_eq($sformatf("k%0d rst_busy", k), int'(busy_w[k]), 0);
            check_eq($sformatf("k%0d rst_done", k), int'(done_w[k]), 0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Directed frames: single byte, back-to-back pair, two stop bits, parity patterns.
        push_byte(0, 8'h55);
        wait_idle();
        push_byte(0, 8'hA5);
        push_byte(0, 8'h3C);
        wait_idle();
        push_byte(1, 8'hFF);
        wait_idle();
        push_byte(0, 8'h07); push_byte(0, 8'h03);
        push_byte(1, 8'h07); push_byte(1, 8'h03);
        wait_idle();

        // fifo_empty chatter in the middle of a frame must not cause a pop.
        push_byte(0, 8'h5A);
        n = 0;
        while (!busy_w[0] && n < 50) begin @(negedge clk); n++; end
        check_eq("glitch_frame_started", int'(busy_w[0]), 1);
        repeat (25) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            glitch0 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        glitch0 = 1'b0;
        wait_idle();

        // Random bytes with random spacing, sometimes queued behind a running frame.
        for (int i = 0; i < 24; i++) begin
            push_byte(int'($urandom_range(0, 1)), W'($urandom));
            repeat ($urandom_range(0, 120)) @(negedge clk);
        end
        wait_idle();

        // Asynchronous reset at cycle 35 of a 0x00 frame.
        mon_en = 1'b0;
        fq0.push_back(8'h00);
        pushes[0]++;
        n = 0;
        while (tx_w[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check_eq("rst_frame_started", int'(tx_w[0]), 0);
        repeat (34) @(negedge clk);
        check_eq("rst_tx_low_before", int'(tx_w[0]), 0);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_tx", int'(tx_w[0]), 1);
        check_eq("rst_async_busy", int'(busy_w[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (fifo_read_w[0] || !tx_w[0] || busy_w[0]) bad++;
        end
        check_eq("post_rst_quiet", bad, 0);

        check_eq("reads_k0", reads[0], pushes[0]);
        check_eq("reads_k1", reads[1], pushes[1]);
        check_eq("frames_left_k0", eq0.size(), 0);
        check_eq("frames_left_k1", eq1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
